// File: rtl/i2s_pkg.sv
// Shared I2S definitions: channel encoding on lrclk, receiver FSM states and
// the bit-counter width helper.
package i2s_pkg;

   localparam logic I2S_LEFT  = 1'b0;
   localparam logic I2S_RIGHT = 1'b1;

   typedef enum logic [1:0] {
      HUNT,
      LEFT,
      RIGHT
   } i2s_state_e;

   // Counter must reach DATA_WIDTH itself (saturation value), hence +1.
   function automatic int unsigned cnt_width(input int unsigned data_width);
      return $clog2(data_width + 1);
   endfunction

endpackage

// File: rtl/i2s_rx_sync_edge.sv
// Multi-stage synchroniser for one edge-detected line plus WIDTH plain data
// lines. The synchronised data and the rise strobe are registered together so
// that data_o holds the values seen at the same instant the edge was seen.
module sync_edge #(
   parameter int unsigned WIDTH       = 1,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             edge_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o,
   output logic             rise_o
);

   // Bit 0 carries the edge-detected line, upper bits the data lines.
   logic [WIDTH:0] stage_q [SYNC_STAGES];
   logic [WIDTH:0] sync_q;
   logic           rise_q;

   // Synchroniser chain, last-stage copy and registered rising-edge strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
            stage_q[i] <= '0;
         end
         sync_q <= '0;
         rise_q <= 1'b0;
      end else begin
         stage_q[0] <= {data_i, edge_i};
         for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
         sync_q <= stage_q[SYNC_STAGES-1];
         rise_q <= stage_q[SYNC_STAGES-1][0] & ~sync_q[0];
      end
   end

   assign data_o = sync_q[WIDTH:1];
   assign rise_o = rise_q;

endmodule

// File: rtl/i2s_rx.sv
// I2S (Philips) slave receiver: synchronises sck/lrclk/sdata into clk, shifts
// in MSB-first slots on sck rising edges and publishes a stereo frame with a
// one-clk frame_valid strobe once a LEFT+RIGHT pair has been received.
module i2s_rx
   import i2s_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  sck,
   input  logic                  lrclk,
   input  logic                  sdata,
   output logic [DATA_WIDTH-1:0] left_chan,
   output logic [DATA_WIDTH-1:0] right_chan,
   output logic                  frame_valid,
   output logic                  slot_err
);

   localparam int unsigned CW = cnt_width(DATA_WIDTH);

   logic [1:0]            rst_sync_q;
   logic                  rst_int_n;
   logic [1:0]            sync_w;
   logic                  bit_tick;
   logic                  s_lrclk;
   logic                  s_sdata;

   i2s_state_e            state_q, state_d;
   logic                  lr_prev_q, lr_prev_d;
   logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [DATA_WIDTH-1:0] left_hold_q, left_hold_d;
   logic [DATA_WIDTH-1:0] left_q, left_d;
   logic [DATA_WIDTH-1:0] right_q, right_d;
   logic                  fv_q, fv_d;
   logic                  err_q, err_d;
   logic [DATA_WIDTH-1:0] slot;
   logic                  short_slot;

   // Reset: asserted asynchronously, released synchronously to clk.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_sync_q <= '0;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end

   assign rst_int_n = rst_sync_q[1];

   sync_edge #(
      .WIDTH       (2),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk    (clk),
      .rst_n  (rst_int_n),
      .edge_i (sck),
      .data_i ({sdata, lrclk}),
      .data_o (sync_w),
      .rise_o (bit_tick)
   );

   assign s_lrclk = sync_w[0];
   assign s_sdata = sync_w[1];

   // Slot content including the current bit at its MSB-first position, and
   // whether a slot ending now would have fewer than DATA_WIDTH bits.
   always_comb begin
      slot = shift_q;
      if (bit_cnt_q < CW'(DATA_WIDTH)) begin
         for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            if (bit_cnt_q == CW'(DATA_WIDTH - 1 - i)) begin
               slot[i] = s_sdata;
            end
         end
      end
      short_slot = (bit_cnt_q < CW'(DATA_WIDTH - 1));
   end

   // Next-state / output logic: boundary handling commits slots, otherwise shift.
   always_comb begin
      state_d     = state_q;
      lr_prev_d   = lr_prev_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      left_hold_d = left_hold_q;
      left_d      = left_q;
      right_d     = right_q;
      fv_d        = 1'b0;
      err_d       = 1'b0;
      if (bit_tick) begin
         if (s_lrclk != lr_prev_q) begin
            // The bit sampled at a boundary is still the LSB of the ending slot.
            lr_prev_d = s_lrclk;
            bit_cnt_d = '0;
            shift_d   = '0;
            unique case (state_q)
               HUNT: begin
                  if (s_lrclk == I2S_LEFT) begin
                     state_d = LEFT;
                  end
               end
               LEFT: begin
                  left_hold_d = slot;
                  err_d       = short_slot;
                  state_d     = RIGHT;
               end
               RIGHT: begin
                  left_d  = left_hold_q;
                  right_d = slot;
                  fv_d    = 1'b1;
                  err_d   = short_slot;
                  state_d = LEFT;
               end
               default: state_d = HUNT;
            endcase
         end else begin
            shift_d = slot;
            if (bit_cnt_q < CW'(DATA_WIDTH)) begin
               bit_cnt_d = bit_cnt_q + 1'b1;
            end
         end
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         state_q     <= HUNT;
         lr_prev_q   <= 1'b0;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         left_hold_q <= '0;
         left_q      <= '0;
         right_q     <= '0;
         fv_q        <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         lr_prev_q   <= lr_prev_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         left_hold_q <= left_hold_d;
         left_q      <= left_d;
         right_q     <= right_d;
         fv_q        <= fv_d;
         err_q       <= err_d;
      end
   end

   assign left_chan   = left_q;
   assign right_chan  = right_q;
   assign frame_valid = fv_q;
   assign slot_err    = err_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: a bus-functional I2S transmitter drives two receivers
// (32-bit and 16-bit capture) and a slot-level model predicts every frame.
module tb_i2s_rx;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        sck   = 1'b0;
   logic        lrclk = 1'b1;
   logic        sdata = 1'b0;

   logic [31:0] l32, r32;
   logic        fv32, err32;
   logic [15:0] l16, r16;
   logic        fv16, err16;

   i2s_rx #(.DATA_WIDTH(32), .SYNC_STAGES(2)) dut32 (
      .clk(clk), .rst_n(rst_n), .sck(sck), .lrclk(lrclk), .sdata(sdata),
      .left_chan(l32), .right_chan(r32), .frame_valid(fv32), .slot_err(err32)
   );

   i2s_rx #(.DATA_WIDTH(16), .SYNC_STAGES(3)) dut16 (
      .clk(clk), .rst_n(rst_n), .sck(sck), .lrclk(lrclk), .sdata(sdata),
      .left_chan(l16), .right_chan(r16), .frame_valid(fv16), .slot_err(err16)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] l;
      logic [31:0] r;
      logic        e;
   } frm_t;

   frm_t        obs32[$], obs16[$], exp32[$], exp16[$];
   int          errp32 = 0, errp16 = 0;
   int          ob32 = 0, ob16 = 0, eb32 = 0, eb16 = 0;
   int          experr32 = 0, experr16 = 0;
   int          checks = 0, errors = 0;
   logic        carry = 1'b0;
   logic [31:0] ml32 = '0, mr32 = '0, ml16 = '0, mr16 = '0;

   // Observation recorder: every frame_valid pulse and every slot_err pulse.
   always @(negedge clk) begin
      if (fv32) obs32.push_back('{l: l32, r: r32, e: err32});
      if (fv16) obs16.push_back('{l: {16'h0, l16}, r: {16'h0, r16}, e: err16});
      if (err32) errp32++;
      if (err16) errp16++;
   end

   // A w-bit slot is MSB-aligned into the receiver word: truncated or zero-padded.
   function automatic logic [31:0] model(input logic [31:0] v, input int w, input int dw);
      logic [63:0] x;
      x = 64'(v) & ((64'd1 << w) - 64'd1);
      x = x << (64 - w);
      return 32'(x >> (64 - dw));
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic send_bit(input logic lr, input logic d);
      lrclk = lr;
      sdata = d;
      #40 sck = 1'b1;
      #40 sck = 1'b0;
   endtask

   // Bits k0..k1-1 of a slot; position 0 carries the previous slot's LSB.
   task automatic send_slot(input logic lr, input logic [31:0] v, input int w,
                            input int k0, input int k1);
      for (int k = k0; k < k1; k++) begin
         if (k == 0) send_bit(lr, carry);
         else        send_bit(lr, v[w-k]);
      end
      if (k1 == w) carry = v[0];
   endtask

   task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int w);
      send_slot(1'b0, l, w, 0, w);
      send_slot(1'b1, r, w, 0, w);
      ml32 = model(l, w, 32);
      mr32 = model(r, w, 32);
      ml16 = model(l, w, 16);
      mr16 = model(r, w, 16);
      exp32.push_back('{l: ml32, r: mr32, e: (w < 32)});
      exp16.push_back('{l: ml16, r: mr16, e: (w < 16)});
      experr32 += (w < 32) ? 2 : 0;
      experr16 += (w < 16) ? 2 : 0;
   endtask

   task automatic prelude(input int w);
      send_slot(1'b1, $urandom, w, 0, w);
   endtask

   // Start a new left slot so the last right slot gets committed.
   task automatic close_frames();
      send_bit(1'b0, carry);
      repeat (3) send_bit(1'b0, 1'b0);
      repeat (20) @(negedge clk);
   endtask

   task automatic chk_out(input string tag);
      chk({tag, "/l32"}, l32, ml32);
      chk({tag, "/r32"}, r32, mr32);
      chk({tag, "/l16"}, {16'h0, l16}, ml16);
      chk({tag, "/r16"}, {16'h0, r16}, mr16);
   endtask

   task automatic check_frames(input string tag);
      chk({tag, "/n32"}, 32'(obs32.size() - ob32), 32'(exp32.size()));
      for (int i = 0; i < exp32.size(); i++) begin
         if (ob32 + i < obs32.size()) begin
            chk({tag, "/f32.l"}, obs32[ob32+i].l, exp32[i].l);
            chk({tag, "/f32.r"}, obs32[ob32+i].r, exp32[i].r);
            chk({tag, "/f32.e"}, 32'(obs32[ob32+i].e), 32'(exp32[i].e));
         end
      end
      chk({tag, "/err32"}, 32'(errp32 - eb32), 32'(experr32));
      chk({tag, "/n16"}, 32'(obs16.size() - ob16), 32'(exp16.size()));
      for (int i = 0; i < exp16.size(); i++) begin
         if (ob16 + i < obs16.size()) begin
            chk({tag, "/f16.l"}, obs16[ob16+i].l, exp16[i].l);
            chk({tag, "/f16.r"}, obs16[ob16+i].r, exp16[i].r);
            chk({tag, "/f16.e"}, 32'(obs16[ob16+i].e), 32'(exp16[i].e));
         end
      end
      chk({tag, "/err16"}, 32'(errp16 - eb16), 32'(experr16));
      ob32 = obs32.size();
      ob16 = obs16.size();
      eb32 = errp32;
      eb16 = errp16;
      exp32.delete();
      exp16.delete();
      experr32 = 0;
      experr16 = 0;
   endtask

   // Outputs must clear as soon as rst_n falls, without waiting for clk.
   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      #1;
      ml32 = '0; mr32 = '0; ml16 = '0; mr16 = '0;
      chk_out(tag);
      chk({tag, "/fv32"},  32'(fv32),  32'd0);
      chk({tag, "/err32"}, 32'(err32), 32'd0);
      chk({tag, "/fv16"},  32'(fv16),  32'd0);
      chk({tag, "/err16"}, 32'(err16), 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      repeat (5) @(negedge clk);
      ob32 = obs32.size();
      ob16 = obs16.size();
      eb32 = errp32;
      eb16 = errp16;
      exp32.delete();
      exp16.delete();
      experr32 = 0;
      experr16 = 0;
   endtask

   initial begin
      logic [31:0] n;

      do_reset("reset");

      // Basic frame straight after hunting.
      prelude(32);
      send_frame(32'h80000001, 32'hAB55AB55, 32);
      close_frames();
      check_frames("t1");
      chk_out("t1");

      // Eight frames with L=n, R=~n.
      do_reset("reset2");
      prelude(32);
      for (int f = 0; f < 8; f++) begin
         n = $urandom;
         send_frame(n, ~n, 32);
      end
      close_frames();
      check_frames("t2");
      chk_out("t2");

      // lrclk held low: no frame, outputs hold the last frame.
      for (int b = 0; b < 200; b++) begin
         send_bit(1'b0, 1'($urandom_range(0, 1)));
      end
      repeat (20) @(negedge clk);
      check_frames("t6");
      chk_out("t6");

      // 24-bit slots: short for 32-bit capture, truncated for 16-bit capture.
      do_reset("reset3");
      prelude(24);
      for (int f = 0; f < 3; f++) begin
         send_frame(32'h00FFFFFF, $urandom & 32'h00FFFFFF, 24);
      end
      close_frames();
      check_frames("t3");
      chk_out("t3");

      // 32-bit slots: full for 32-bit capture, truncated for 16-bit capture.
      do_reset("reset4");
      prelude(32);
      for (int f = 0; f < 3; f++) begin
         send_frame($urandom, 32'h1234ABCD, 32);
      end
      close_frames();
      check_frames("t4");
      chk_out("t4");

      // Reset in the middle of a right slot: interrupted frame is dropped.
      do_reset("reset5");
      prelude(32);
      send_frame(32'hCAFEF00D, 32'h0BADBEEF, 32);
      send_slot(1'b0, 32'h11111111, 32, 0, 32);
      repeat (20) @(negedge clk);
      check_frames("t5a");
      chk_out("t5a");
      send_slot(1'b1, 32'h22222222, 32, 0, 10);
      do_reset("t5rst");
      send_slot(1'b1, 32'h22222222, 32, 10, 32);
      n = $urandom;
      send_frame(n, n ^ 32'h5A5A5A5A, 32);
      close_frames();
      check_frames("t5b");
      chk_out("t5b");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
